mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 59 +++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of all bus signals around the RAM arbiter.
//   host port : h_req, h_we, h_addr, h_wdata -> h_gnt, h_rvalid, h_rdata
//   core port : c_req, c_we, c_addr, c_wdata -> c_gnt, c_rvalid, c_rdata
//   lock      : h_lock (host asks for exclusive ownership) -> locked
//   RAM port  : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (1-cycle read)
// slave  : arbiter side
// master : requesters plus RAM side (testbench / surrounding system)

interface mem_arbiter_if #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
);
    logic                 h_req;
    logic                 h_we;
    logic [ADDR_BITS-1:0] h_addr;
    logic [DATA_BITS-1:0] h_wdata;
    logic                 h_gnt;
    logic                 h_rvalid;
    logic [DATA_BITS-1:0] h_rdata;

    logic                 c_req;
    logic                 c_we;
    logic [ADDR_BITS-1:0] c_addr;
    logic [DATA_BITS-1:0] c_wdata;
    logic                 c_gnt;
    logic                 c_rvalid;
    logic [DATA_BITS-1:0] c_rdata;

    logic                 h_lock;
    logic                 locked;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;

    modport slave (
        input  h_req, h_we, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  h_lock,
        output locked,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output h_req, h_we, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output h_lock,
        input  locked,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (host loader / core) arbiter in front of a
// single-port RAM with one-cycle read latency.
//   clk   : rising-edge clock
//   rst_n : synchronous, active-low reset
//   bus   : mem_arbiter_if.slave (host port, core port, lock, RAM port)
// Grants are combinational from the current requests; ties are resolved
// round-robin, with a starvation override for the core. The host can take
// exclusive ownership through a lock sequence.
//
// state  | meaning
// OPEN   | normal round-robin arbitration between host and core
// DRAIN  | lock requested; core blocked, one cycle for in-flight core reads
// LOCKED | host owns the RAM exclusively, locked=1

module mem_arbiter #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        OPEN   = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'd8;
    localparam logic [3:0] STARVE_MAX   = 4'd15;

    lock_state_t state_q, state_d;
    logic        last_host_q;   // 1 when the host won the most recent grant
    logic [3:0]  starve_q;
    logic        h_pend_q, c_pend_q;
    logic        h_gnt, c_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OPEN;
            last_host_q <= 1'b0;
            starve_q    <= 4'd0;
            h_pend_q    <= 1'b0;
            c_pend_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (h_gnt)
                last_host_q <= 1'b1;
            else if (c_gnt)
                last_host_q <= 1'b0;
            // Leaving LOCKED: pretend the host won last so the core takes
            // the first tie after unlock.
            if (state_q == LOCKED && !bus.h_lock)
                last_host_q <= 1'b1;

            if (c_gnt || !bus.c_req)
                starve_q <= 4'd0;
            else if (starve_q != STARVE_MAX)
                starve_q <= starve_q + 4'd1;

            h_pend_q <= h_gnt && !bus.h_we;
            c_pend_q <= c_gnt && !bus.c_we;
        end
    end

    always_comb begin
        state_d = state_q;
        h_gnt   = 1'b0;
        c_gnt   = 1'b0;
        case (state_q)
            OPEN: begin
                if (bus.h_lock)
                    state_d = DRAIN;
                if (bus.h_req && bus.c_req) begin
                    if (starve_q >= STARVE_LIMIT || last_host_q)
                        c_gnt = 1'b1;
                    else
                        h_gnt = 1'b1;
                end else begin
                    h_gnt = bus.h_req;
                    c_gnt = bus.c_req;
                end
            end
            DRAIN: begin
                state_d = bus.h_lock ? LOCKED : OPEN;
                h_gnt   = bus.h_req;
            end
            LOCKED: begin
                if (!bus.h_lock)
                    state_d = OPEN;
                h_gnt = bus.h_req;
            end
            default: state_d = OPEN;
        endcase
        // Outputs must be quiet for the whole reset window, not just after
        // the first reset edge.
        if (!rst_n) begin
            h_gnt = 1'b0;
            c_gnt = 1'b0;
        end
    end

    always_comb begin
        bus.mem_en    = h_gnt || c_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_BITS{1'b0}};
        bus.mem_wdata = {DATA_BITS{1'b0}};
        if (h_gnt) begin
            bus.mem_we    = bus.h_we;
            bus.mem_addr  = bus.h_addr;
            bus.mem_wdata = bus.h_wdata;
        end else if (c_gnt) begin
            bus.mem_we    = bus.c_we;
            bus.mem_addr  = bus.c_addr;
            bus.mem_wdata = bus.c_wdata;
        end
    end

    assign bus.h_gnt    = h_gnt;
    assign bus.c_gnt    = c_gnt;
    assign bus.h_rvalid = h_pend_q && rst_n;
    assign bus.c_rvalid = c_pend_q && rst_n;
    assign bus.h_rdata  = bus.h_rvalid ? bus.mem_rdata : {DATA_BITS{1'b0}};
    assign bus.c_rdata  = bus.c_rvalid ? bus.mem_rdata : {DATA_BITS{1'b0}};
    assign bus.locked   = (state_q == LOCKED) && rst_n;

endmodule
